// File: rtl/main_pkg.sv
// ============================================================================
// Module : main_pkg
// Brief  : Shared mode encodings, unit price table and stock limits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package main_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_BUY  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam int unsigned NUM_ITEMS = 8;

    localparam logic [7:0] PRICE [0:NUM_ITEMS-1] = '{
        8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8, 8'd10, 8'd12
    };

    localparam logic [3:0] INIT_STOCK = 4'd5;
    localparam logic [3:0] STOCK_MAX  = 4'd15;

endpackage

`default_nettype wire

// File: rtl/main_price_lookup.sv
// ============================================================================
// Module : price_lookup
// Brief  : Combinational cost = unit price of the item times requested units.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module price_lookup
    import main_pkg::*;
(
    input  logic [2:0] supply_type,
    input  logic [3:0] customer_amount,
    output logic [7:0] cost
);

    // Largest product is 12 * 15 = 180, so 8 bits never wrap.
    always_comb begin
        cost = PRICE[supply_type] * {4'd0, customer_amount};
    end

endmodule

`default_nettype wire

// File: rtl/main.sv
// ============================================================================
// Module : main
// Brief  : Eight-item vending stock keeper; acts once per mode entry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module main
    import main_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [6:0] customer_money,
    input  logic [2:0] supply_type,
    input  logic [3:0] customer_amount,
    input  logic [3:0] amount_sypply_to_add,
    output logic       error
);

    logic [3:0] stock [0:NUM_ITEMS-1];
    logic [1:0] prev_mode;

    logic [7:0] cost;
    logic       entry;
    logic [3:0] cur_stock;
    logic [4:0] add_sum;
    logic       buy_ok;
    logic       next_error;
    logic       stock_we;
    logic [3:0] stock_wdata;

    price_lookup u_price_lookup (
        .supply_type     (supply_type),
        .customer_amount (customer_amount),
        .cost            (cost)
    );

    assign entry     = (mode != prev_mode);
    assign cur_stock = stock[supply_type];
    assign add_sum   = {1'b0, cur_stock} + {1'b0, amount_sypply_to_add};
    assign buy_ok    = (customer_amount != 4'd0)
                     && (cur_stock >= customer_amount)
                     && ({1'b0, customer_money} >= cost);

    always_comb begin
        next_error  = error;
        stock_we    = 1'b0;
        stock_wdata = cur_stock;
        unique case (mode_t'(mode))
            MODE_IDLE: next_error = 1'b0;
            MODE_BUY: begin
                next_error  = ~buy_ok;
                stock_we    = buy_ok;
                stock_wdata = cur_stock - customer_amount;
            end
            MODE_ADD: begin
                // An overflowing restock is rejected whole, never clamped.
                stock_we    = (add_sum <= {1'b0, STOCK_MAX});
                next_error  = ~stock_we;
                stock_wdata = add_sum[3:0];
            end
            MODE_RSVD: next_error = 1'b1;
            default:   next_error = error;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_mode <= MODE_IDLE;
            error     <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= INIT_STOCK;
            end
        end else begin
            prev_mode <= mode;
            if (entry) begin
                error <= next_error;
                if (stock_we) begin
                    stock[supply_type] <= stock_wdata;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main.sv
// ============================================================================
// Module : tb_main
// Brief  : Directed and random checks of main against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_main;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [6:0] customer_money;
    logic [2:0] supply_type;
    logic [3:0] customer_amount;
    logic [3:0] amount_sypply_to_add;
    logic       error;

    int vectors;
    int miscompares;

    int m_stock [8];
    int m_prev;
    int m_err;
    int prices [8] = '{2, 3, 4, 5, 6, 8, 10, 12};

    main dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mode                 (mode),
        .customer_money       (customer_money),
        .supply_type          (supply_type),
        .customer_amount      (customer_amount),
        .amount_sypply_to_add (amount_sypply_to_add),
        .error                (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_stock[i] = 5;
        m_prev = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input int m, input int money, input int t,
                              input int amt, input int add);
        int cost;
        if (m != m_prev) begin
            case (m)
                0: m_err = 0;
                1: begin
                    cost = prices[t] * amt;
                    if (amt != 0 && m_stock[t] >= amt && money >= cost) begin
                        m_stock[t] = m_stock[t] - amt;
                        m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                2: begin
                    if (m_stock[t] + add <= 15) begin
                        m_stock[t] = m_stock[t] + add;
                        m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                default: m_err = 1;
            endcase
        end
        m_prev = m;
    endtask

    task automatic check_all(input string tag);
        vectors++;
        assert (error === m_err[0]) else begin
            miscompares++;
            $error("FAIL %s error: observed %0b expected %0d", tag, error, m_err);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            assert (dut.stock[i] === m_stock[i][3:0]) else begin
                miscompares++;
                $error("FAIL %s stock[%0d]: observed %0d expected %0d",
                       tag, i, dut.stock[i], m_stock[i]);
            end
        end
    endtask

    task automatic check_const(input string tag, input logic [3:0] obs,
                               input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input int m, input int money, input int t,
                         input int amt, input int add, input string tag);
        mode                 = m[1:0];
        customer_money       = money[6:0];
        supply_type          = t[2:0];
        customer_amount      = amt[3:0];
        amount_sypply_to_add = add[3:0];
        @(posedge clk);
        #1;
        model_step(m, money, t, amt, add);
        check_all(tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        mode = 2'd0;
        customer_money = 7'd0;
        supply_type = 3'd0;
        customer_amount = 4'd0;
        amount_sypply_to_add = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply(1, 20, 3, 2, 0, "buy_ok");
        check_const("buy_ok stock3", dut.stock[3], 4'd3);
        check_const("buy_ok err", {3'd0, error}, 4'd0);
        for (int k = 0; k < 5; k++) apply(1, 20, 3, 2, 0, "hold_buy");
        check_const("hold stock3", dut.stock[3], 4'd3);

        apply(0, 0, 0, 0, 0, "idle");
        apply(1, 20, 7, 2, 0, "buy_poor");
        check_const("buy_poor err", {3'd0, error}, 4'd1);

        apply(0, 0, 0, 0, 0, "idle");
        apply(1, 127, 0, 6, 0, "buy_short");
        check_const("buy_short err", {3'd0, error}, 4'd1);
        apply(2, 0, 0, 0, 10, "restock_full");
        check_const("restock stock0", dut.stock[0], 4'd15);
        apply(0, 0, 0, 0, 0, "idle");
        apply(2, 0, 0, 0, 1, "restock_ovf");
        check_const("restock_ovf err", {3'd0, error}, 4'd1);
        apply(1, 127, 1, 0, 0, "buy_zero");
        apply(2, 0, 1, 0, 0, "restock_zero");

        apply(3, 0, 0, 0, 0, "rsvd");
        check_const("rsvd err", {3'd0, error}, 4'd1);
        apply(0, 0, 0, 0, 0, "rsvd_clear");
        check_const("clear err", {3'd0, error}, 4'd0);

        apply(1, 20, 3, 2, 0, "buy_before_rst");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            int m;
            m = (($urandom_range(0, 3) == 0) ? m_prev : int'($urandom_range(0, 3)));
            apply(m, int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 The block SHALL have ports clk (input, 1, rising-edge system clock) and rst_n (input, 1, reset); one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have port mode (input, 2): 0 idle, 1 purchase, 2 restock, 3 reserved.
REQ-003 The block SHALL have port customer_money (input, 7): money inserted, unsigned 0..127.
REQ-004 The block SHALL have port supply_type (input, 3): item index 0..7.
REQ-005 The block SHALL have port customer_amount (input, 4): units requested, 0..15.
REQ-006 The block SHALL have port amount_sypply_to_add (input, 4): units to restock, 0..15; the spelling is fixed.
REQ-007 The block SHALL have port error (output, 1, registered): 1 means the last operation was rejected.

Function
REQ-008 The block SHALL hold eight 4-bit stock counters, one per supply_type.
REQ-009 Fixed unit prices SHALL be PRICE[0..7] = 2, 3, 4, 5, 6, 8, 10, 12.
REQ-010 The block SHALL register mode into prev_mode every clock.
REQ-011 An operation SHALL execute only on a rising edge where mode != prev_mode (mode-entry edge), exactly once per entry.
REQ-012 Holding mode steady SHALL repeat nothing.
REQ-013 Purchase (entry into mode 1): cost = PRICE[supply_type] * customer_amount, 8-bit unsigned; customer_money SHALL be zero-extended to 8 bits for comparison.
REQ-014 Purchase SHALL succeed iff customer_amount != 0, stock[supply_type] >= customer_amount, and customer_money >= cost.
REQ-015 On purchase success, stock[supply_type] SHALL decrease by customer_amount and error SHALL be 0.
REQ-016 On purchase failure, stock SHALL be unchanged and error SHALL be 1.
REQ-017 Restock (entry into mode 2): a 5-bit sum = stock[supply_type] + amount_sypply_to_add SHALL be formed.
REQ-018 If the restock sum is <= 15, stock SHALL be updated and error SHALL be 0; otherwise (overflow) stock SHALL be unchanged and error SHALL be 1.
REQ-019 Restock with an amount of 0 SHALL be legal and SHALL set error to 0.
REQ-020 Entry into mode 3 SHALL set error to 1 and change no stock.
REQ-021 Entry into mode 0 SHALL clear error to 0.
REQ-022 Between operations, error SHALL hold its value.
REQ-023 Latency: inputs SHALL be sampled on the entry edge, with the result visible on error and stock immediately after that same edge (1 cycle).
REQ-024 A mode change from 1 directly to 2, or 2 directly to 1, SHALL count as a new entry and execute.
REQ-025 Only the addressed counter SHALL change; the other seven are untouched.

Reset
REQ-026 While rst_n = 0, regardless of clk: all stock counters = 5, error = 0, prev_mode = 0.
REQ-027 A reset asserted mid-operation SHALL abandon the operation with no partial stock update.
REQ-028 After release, the first edge with mode != 0 SHALL be treated as an entry.

Structure
REQ-029 A shared package SHALL hold the mode encodings (MODE_IDLE, MODE_BUY, MODE_ADD, MODE_RSVD), the PRICE table, INIT_STOCK = 5, and STOCK_MAX = 15.
REQ-030 One sub-module, price_lookup, SHALL be purely combinational, mapping supply_type and customer_amount to an 8-bit cost.
REQ-031 Stock storage and the decision logic SHALL reside in main.

Verification
REQ-032 Reset; mode 0 -> 1 with money 20, type 3, amount 2 (cost 10) -> error 0, stock[3] = 3.
REQ-033 Hold mode 1 for 5 cycles after REQ-032 -> stock[3] stays 3 (no repeat).
REQ-034 Mode 0 -> 1 with type 7, amount 2, money 20 (cost 24) -> error 1, stock[7] = 5.
REQ-035 Mode 0 -> 1 with type 0, amount 6, money 127 -> error 1 (stock 5 < 6); then mode 2 with add 10 -> error 0, stock[0] = 15; then mode 0 -> 2 with add 1 -> error 1, stock[0] = 15.
REQ-036 Mode 3 entry -> error 1; then mode 0 -> error 0.
REQ-037 Assert rst_n low between clock edges after a purchase -> stock is immediately 5 everywhere and error is 0.
